// File: rtl/srl_iter.sv
// srl_iter: iterative right shifter, one bit per clock, logical or arithmetic fill, valid/ready on both sides
module srl_iter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         arith,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
);
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] NC = CW'(N);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t        r_state, w_next;
  logic [N-1:0]  r_data;
  logic [CW-1:0] r_cnt;
  logic          r_fill;
  logic [CW-1:0] w_k;
  logic          w_accept;
  assign w_k      = (b >= N[N-1:0]) ? NC : CW'(b);
  assign w_accept = (r_state == IDLE) && in_valid;
  // state register; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = in_valid ? ((w_k == '0) ? DONE : SHIFT) : IDLE;
      SHIFT:   w_next = (r_cnt == CW'(1)) ? DONE : SHIFT;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  // handshake outputs are pure state decodes
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end
  // datapath: latch operands at accept, then shift one position per SHIFT cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_fill <= 1'b0;
    end else if (w_accept) begin
      r_data <= a;
      r_cnt  <= w_k;
      r_fill <= arith;
    end else if (r_state == SHIFT) begin
      r_data <= {r_fill ? r_data[N-1] : 1'b0, r_data[N-1:1]};
      r_cnt  <= r_cnt - CW'(1);
    end
  end
  assign out_data = r_data;
endmodule

// File: tb/tb_srl_iter.sv
// tb_srl_iter: scoreboard bench for the iterative right shifter
module tb_srl_iter;
  logic       clk, rst, in_valid, in_ready, arith, out_valid, out_ready;
  logic [7:0] a, b, out_data;
  logic [7:0] sb_q[$];
  int         checks = 0;
  int         errs   = 0;

  srl_iter #(.N(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .arith(arith), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic op(input logic [7:0] ta, input logic [7:0] tb, input logic tar, input int hold);
    logic signed [7:0] sa;
    logic [7:0] exp_d;
    int k, lat;
    k = (tb >= 8) ? 8 : int'(tb);
    sa = ta;
    exp_d = tar ? 8'(sa >>> k) : (ta >> k);
    sb_q.push_back(exp_d);
    chk("in_ready_idle", in_ready, 1);
    a = ta; b = tb; arith = tar; in_valid = 1; out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk("busy_in_ready", in_ready, 0);
      a = 8'($urandom); b = 8'($urandom); arith = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, k);
    for (int i = 0; i < hold; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, exp_d);
      chk("bp_in_ready", in_ready, 0);
      in_valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 0;
    out_ready = 1;
    chk("out_valid", out_valid, 1);
    if (sb_q.size() == 0) chk("sb_empty", 1, 0);
    else chk("result", out_data, sb_q.pop_front());
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
  endtask

  initial begin
    rst = 1; in_valid = 0; a = 0; b = 0; arith = 0; out_ready = 1;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    op(8'hB4, 8'd2, 0, 0);
    op(8'hB4, 8'd2, 1, 0);
    op(8'h34, 8'd2, 1, 0);
    op(8'h5A, 8'd0, 0, 0);
    op(8'h80, 8'd200, 0, 0);
    op(8'h80, 8'd200, 1, 0);
    op(8'h81, 8'd1, 0, 5);
    op(8'h7F, 8'd8, 1, 0);
    op(8'hFF, 8'd7, 1, 1);
    for (int i = 0; i < 24; i++)
      op(8'($urandom), 8'($urandom_range(0, 12)), 1'($urandom), int'($urandom_range(0, 2)));
    // abort mid-shift with an asynchronous reset
    a = 8'hFF; b = 8'd7; arith = 0; in_valid = 1; out_ready = 1;
    sb_q.push_back(8'h01);
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_data", out_data, 0);
    chk("abort_in_ready", in_ready, 1);
    void'(sb_q.pop_back());
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    op(8'hF0, 8'd4, 0, 0);
    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
